// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the two-port data-memory controller.
package dmem_ctrl_pkg;

    localparam int         NUM_PORTS  = 2;
    localparam logic [3:0] BMASK_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } dmem_state_e;

    // Lane i comes from new_w where mask[i] is set, otherwise from old_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Requester-side bus of dmem_ctrl: both ports packed side by side, port 1 in the upper half.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 16
);
    import dmem_ctrl_pkg::*;

    logic [NUM_PORTS-1:0]              i_req_valid;
    logic [NUM_PORTS-1:0]              o_req_ready;
    logic [NUM_PORTS-1:0]              i_req_we;
    logic [NUM_PORTS*(ADDR_W+2)-1:0]   i_req_addr;
    logic [NUM_PORTS*4-1:0]            i_req_bmask;
    logic [NUM_PORTS*32-1:0]           i_req_wdata;
    logic [NUM_PORTS-1:0]              o_rsp_valid;
    logic [31:0]                       o_rsp_rdata;

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_bmask, i_req_wdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_bmask, i_req_wdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata
    );

endinterface

// File: rtl/dmem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the remembered winner only moves when a grant is taken.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Serialises two requesters onto a word-only memory, turning partial stores into atomic read-modify-write.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    dmem_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wren,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam int AW = ADDR_W + 2;

    dmem_state_e       state;
    logic              id_q;
    logic              we_q;
    logic [3:0]        bmask_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic [1:0]        rsp_q;

    logic [1:0]        grant;
    logic              accept;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_idx;
    logic [3:0]        sel_bmask;
    logic [31:0]       sel_wdata;
    logic [1:0]        id_onehot;

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .valid   (bus.i_req_valid),
        .accept  (accept),
        .grant   (grant)
    );

    assign bus.o_req_ready = (state == IDLE && i_rst_n) ? grant : 2'b00;
    assign accept          = |(bus.i_req_valid & bus.o_req_ready);
    assign bus.o_rsp_valid = rsp_q;
    assign bus.o_rsp_rdata = data_q;

    assign sel       = grant[1];
    assign sel_we    = bus.i_req_we[sel];
    assign sel_idx   = sel ? bus.i_req_addr[AW+2 +: ADDR_W] : bus.i_req_addr[2 +: ADDR_W];
    assign sel_bmask = sel ? bus.i_req_bmask[7:4] : bus.i_req_bmask[3:0];
    assign sel_wdata = sel ? bus.i_req_wdata[63:32] : bus.i_req_wdata[31:0];
    assign id_onehot = id_q ? 2'b10 : 2'b01;

    // Memory-side outputs are registered on entry to each state, so they hold for the whole state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            bmask_q     <= 4'h0;
            wdata_q     <= 32'h0;
            data_q      <= 32'h0;
            rsp_q       <= 2'b00;
            o_mem_addr  <= '0;
            o_mem_wren  <= 1'b0;
            o_mem_wdata <= 32'h0;
        end else begin
            rsp_q       <= 2'b00;
            o_mem_wren  <= 1'b0;
            o_mem_wdata <= 32'h0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q    <= sel;
                        we_q    <= sel_we;
                        bmask_q <= sel_bmask;
                        wdata_q <= sel_wdata;
                        if (!sel_we) begin
                            state      <= RD;
                            o_mem_addr <= sel_idx;
                        end else if (sel_bmask == BMASK_FULL) begin
                            state       <= WR;
                            o_mem_addr  <= sel_idx;
                            o_mem_wren  <= 1'b1;
                            o_mem_wdata <= sel_wdata;
                        end else if (sel_bmask == 4'h0) begin
                            state      <= RSP;
                            rsp_q      <= sel ? 2'b10 : 2'b01;
                            o_mem_addr <= '0;
                        end else begin
                            state      <= RD;
                            o_mem_addr <= sel_idx;
                        end
                    end
                end
                RD: begin
                    data_q <= i_mem_rdata;
                    if (!we_q) begin
                        state      <= RSP;
                        rsp_q      <= id_onehot;
                        o_mem_addr <= '0;
                    end else begin
                        state       <= WR;
                        o_mem_wren  <= 1'b1;
                        o_mem_wdata <= merge_bytes(i_mem_rdata, wdata_q, bmask_q);
                    end
                end
                WR: begin
                    data_q     <= o_mem_wdata;
                    state      <= RSP;
                    rsp_q      <= id_onehot;
                    o_mem_addr <= '0;
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and randomised checks of dmem_ctrl against a word-array model of memory.
module tb_dmem_ctrl;

    localparam int ADDR_W = 16;
    localparam int AW     = ADDR_W + 2;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:63];

    dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_mem_addr  (mem_addr),
        .o_mem_wren  (mem_wren),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wren) mem[mem_addr] <= mem_wdata;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [ADDR_W-1:0] idx,
                           input logic [3:0] bm, input logic [31:0] wd);
        bus.i_req_we[p]           = we;
        bus.i_req_addr[p*AW +: AW] = {idx, 2'(p + 1)};
        bus.i_req_bmask[p*4 +: 4] = bm;
        bus.i_req_wdata[p*32 +: 32] = wd;
        bus.i_req_valid[p]        = 1'b1;
    endtask

    // One transaction: expected word, latency and write cycle come from the access kind.
    task automatic do_txn(input int p, input bit we, input logic [ADDR_W-1:0] idx,
                          input logic [3:0] bm, input logic [31:0] wd, output int waited);
        logic [31:0] exp_w;
        int lat, wcyc;
        bit acc;
        exp_w = ref_mem[idx];
        if (we) for (int b = 0; b < 4; b++) if (bm[b]) exp_w[8*b +: 8] = wd[8*b +: 8];
        if (!we)             begin lat = 2; wcyc = 0; end
        else if (bm == 4'hF) begin lat = 2; wcyc = 1; end
        else if (bm == 4'h0) begin lat = 1; wcyc = 0; end
        else                 begin lat = 3; wcyc = 2; end
        @(posedge clk); #1;
        set_req(p, we, idx, bm, wd);
        acc = 0;
        waited = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (bus.o_req_ready[p]) acc = 1; else waited++;
        end
        chk("accept", 64'(acc), 64'd1);
        @(posedge clk); #1;
        bus.i_req_valid[p] = 1'b0;
        if (!acc) return;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            chk("mem_wren", 64'(mem_wren), 64'(n == wcyc));
            chk("mem_addr", 64'(mem_addr), (n < lat) ? 64'(idx) : 64'd0);
            chk("mem_wdata", 64'(mem_wdata), (n == wcyc) ? 64'(exp_w) : 64'd0);
            chk("rsp_valid", 64'(bus.o_rsp_valid), (n == lat) ? 64'(2'b01 << p) : 64'd0);
            if (n == lat && !(we && bm == 4'h0)) chk("rsp_rdata", 64'(bus.o_rsp_rdata), 64'(exp_w));
        end
        if (we) ref_mem[idx] = exp_w;
        @(posedge clk); #1;
        chk("mem_content", 64'(mem[idx]), 64'(ref_mem[idx]));
    endtask

    initial begin
        int w;
        int exp_port;
        int n_grant;
        int q[$];
        bit seen;

        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        bus.i_req_valid = '0;
        bus.i_req_we    = '0;
        bus.i_req_addr  = '0;
        bus.i_req_bmask = '0;
        bus.i_req_wdata = '0;
        rst_n = 1'b0;

        // Reset state, including ready held low even with a valid request.
        repeat (3) @(posedge clk);
        #1;
        bus.i_req_valid = 2'b01;
        @(negedge clk);
        chk("rst_ready", 64'(bus.o_req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.o_rsp_rdata), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wren", 64'(mem_wren), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        bus.i_req_valid = 2'b00;
        rst_n = 1'b1;

        // Both ports loading continuously: grants alternate starting at port 0.
        ref_mem[2] = 32'h0; ref_mem[3] = 32'h0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'd2, 4'h0, 32'h0);
        set_req(1, 1'b0, 16'd3, 4'h0, 32'h0);
        exp_port = 0;
        n_grant  = 0;
        for (int i = 0; i < 36; i++) begin
            if (i == 30) begin
                @(posedge clk); #1;
                bus.i_req_valid = 2'b00;
            end
            @(negedge clk);
            if (bus.o_req_ready != 2'b00) begin
                chk("arb_grant", 64'(bus.o_req_ready), 64'(2'b01 << exp_port));
                q.push_back(exp_port);
                exp_port = 1 - exp_port;
                n_grant++;
            end
            if (bus.o_rsp_valid != 2'b00) begin
                chk("arb_rsp_onehot", 64'($countones(bus.o_rsp_valid)), 64'd1);
                if (q.size() > 0) begin
                    chk("arb_rsp_port", 64'(bus.o_rsp_valid), 64'(2'b01 << q[0]));
                    void'(q.pop_front());
                end else begin
                    chk("arb_rsp_spurious", 64'(bus.o_rsp_valid), 64'd0);
                end
            end
        end
        chk("arb_rsp_drained", 64'(q.size()), 64'd0);
        chk("arb_grant_count_ok", 64'(n_grant >= 8), 64'd1);

        // Full store then load back.
        do_txn(0, 1'b1, 16'd4, 4'hF, 32'hDEADBEEF, w);
        do_txn(0, 1'b0, 16'd4, 4'h0, 32'h0, w);
        // Partial store merges into the preloaded word.
        do_txn(0, 1'b1, 16'd4, 4'hF, 32'h11223344, w);
        do_txn(1, 1'b1, 16'd4, 4'b0010, 32'h0000AA00, w);
        chk("partial_result", 64'(mem[4]), 64'h1122AA44);
        // Zero-mask store leaves memory untouched.
        do_txn(1, 1'b1, 16'd4, 4'h0, 32'hFFFFFFFF, w);
        chk("zero_mask_keep", 64'(mem[4]), 64'h1122AA44);

        // Random single-port traffic against the word-array model.
        for (int t = 0; t < 40; t++) begin
            do_txn(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   16'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), $urandom, w);
        end

        // Reset in the WR cycle of a partial store.
        do_txn(0, 1'b1, 16'd5, 4'hF, 32'hCAFEF00D, w);
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'd5, 4'b0001, 32'h000000EE);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_req_ready[0]) seen = 1;
        end
        chk("rmw_accept", 64'(seen), 64'd1);
        @(posedge clk); #1;
        bus.i_req_valid = 2'b00;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_wren) seen = 1;
        end
        chk("rmw_reach_wr", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_wren", 64'(mem_wren), 64'd0);
        chk("rst_drop_ready", 64'(bus.o_req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(bus.o_rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        chk("rst_word_kept", 64'(mem[5]), 64'hCAFEF00D);

        // After reset last_grant=1: a lone port 1 is granted without waiting.
        do_txn(1, 1'b0, 16'd5, 4'h0, 32'h0, w);
        chk("p1_alone_wait", 64'(w), 64'd0);
        do_txn(0, 1'b1, 16'd5, 4'b1000, 32'h5A000000, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Two-port controller that shares the single-port, word-wide data memory between the core LSU (port 0) and the loader/debug master (port 1). It arbitrates round-robin, serialises accesses through a small FSM and converts byte-masked stores into read-modify-write sequences, because the memory writes whole 32-bit words only. It sits between the requesters and the memory's `i_lsu_addr`/`wren`/`i_wdata`/`o_data_dmem` pins; the memory read path is combinational.

## Interface
- `ADDR_W`, 16: word-index width driven to memory; requester byte addresses are `ADDR_W+2` bits.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req_valid` in 2: request valid, bit p = port p.
- `o_req_ready` out 2: request accepted this cycle when valid&ready.
- `i_req_we` in 2: 1 = store, 0 = load.
- `i_req_addr` in 2*(ADDR_W+2): byte addresses, port 1 in upper half; bits [1:0] ignored.
- `i_req_bmask` in 8: byte-lane enables, 4 per port, port 1 upper; lanes already aligned by requester.
- `i_req_wdata` in 64: store data, port 1 upper.
- `o_rsp_valid` out 2: one-cycle completion pulse to port p.
- `o_rsp_rdata` out 32: load word, or final written word for stores.
- `o_mem_addr` out ADDR_W: word index to memory.
- `o_mem_wren` out 1: memory write enable.
- `o_mem_wdata` out 32: memory write data.
- `i_mem_rdata` in 32: combinational memory read data.

## Operation
- States: IDLE, RD, WR, RSP. One transaction in flight; the memory is never shared mid-transaction, so RMW is atomic.
- IDLE: `o_req_ready` asserts only for the granted port (one-hot or 0). On accept, latch port id, we, word index, bmask and wdata.
  - load: go to RD.
  - store with bmask 4'hF: go to WR.
  - store with bmask 4'h0: go to RSP (no memory write).
  - other stores: go to RD.
- RD: drive `o_mem_addr` = latched index and capture `i_mem_rdata` into the data register. Loads go to RSP; partial stores go to WR.
- WR: `o_mem_wren`=1. `o_mem_wdata` takes lane i from wdata when bmask[i]=1, else from the captured word. The full-word path uses wdata directly. The driven word is also stored into the data register. Go to RSP.
- RSP: `o_rsp_valid[id]`=1 for exactly one cycle, `o_rsp_rdata` = data register. Go to IDLE. There is no response back-pressure.
- Arbitration: `last_grant` register. When both ports are valid, grant the port != `last_grant`; a single valid port is granted directly. `last_grant` updates on accept only.
- `o_mem_addr` = 0 in IDLE and RSP; `o_mem_wdata` = 0 outside WR.

## Timing
- Accept edge = k. Responses:
  - load: `o_rsp_valid` in cycle k+2.
  - full store: write edge at k+1 end, response at k+2.
  - partial store: read in k+1, write in k+2, response at k+3.
  - zero-mask store: response at k+1.
- Next accept is possible in the cycle after RSP. Peak throughput: 1 load per 3 cycles.
- Reset values: state IDLE, `last_grant`=1 (port 0 wins first tie), data register 0, all outputs 0. `o_req_ready` is forced to 0 while `i_rst_n`=0.
- Reset asserted mid-transaction: FSM goes to IDLE asynchronously and `o_mem_wren` drops immediately. The pending write is not performed, no response is issued and the requester must reissue.
- A valid that is withdrawn before accept has no effect. Requesters must hold request fields stable while valid && !ready.

## Structure
- `dmem_ctrl_pkg`: state enum `dmem_state_e`, `NUM_PORTS`=2, `BMASK_FULL`=4'hF, and a `merge_bytes(old, new, mask)` function.
- Sub-module `rr_arb2`: 2-way round-robin arbiter (valid in, grant out, update on accept, holds `last_grant`).
- FSM, latch registers and merge live in `dmem_ctrl`.

## Test plan
- Port 0 store, addr 0x10, bmask F, data 0xDEADBEEF, then load 0x10 → write edge at k+1 with `o_mem_addr`=4; load response at k+2 with rdata 0xDEADBEEF.
- Preload word 4 = 0x11223344; port 1 store, bmask 4'b0010, data 0x0000AA00 → RD then WR of 0x1122AA44, `o_rsp_valid[1]` at k+3 with rdata 0x1122AA44.
- Both ports valid continuously with loads → grants alternate 0,1,0,1 starting with port 0 after reset; exactly one `o_rsp_valid` bit per transaction.
- Store with bmask 0 → no `o_mem_wren` pulse, response at k+1, memory contents unchanged.
- Reset asserted in the WR cycle of a partial store → `o_mem_wren` falls with `i_rst_n`, target word unchanged, no response, next request accepted normally.
- Port 1 alone valid while port 0 idle, `last_grant`=1 → port 1 granted immediately, with no waiting for fairness.
